// File: rtl/iq_filter_sched.sv
// I/Q sample scheduler for the shared FIR engine: one-pair holding register,
// I-then-Q job sequencing with decimation flags, watchdog and stall counter.
module iq_filter_sched #(
  parameter int DATA_W  = 12,
  parameter int DECIM   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_i,
  input  logic [DATA_W-1:0] adc_q,
  output logic              adc_ready,
  output logic              flt_start,
  output logic              flt_sel,
  output logic [DATA_W-1:0] flt_data,
  output logic              flt_emit,
  input  logic              flt_done,
  output logic              busy,
  output logic              err,
  output logic [15:0]       stall_cnt
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [DW-1:0] DMAX = DW'(DECIM - 1);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_I,
    WAIT_I,
    START_Q,
    WAIT_Q
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] i_reg_q, i_reg_d;
  logic [DATA_W-1:0] q_reg_q, q_reg_d;
  logic              pair_full_q, pair_full_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic              err_q, err_d;
  logic [15:0]       stall_q, stall_d;
  logic              start_q, start_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              emit_q, emit_d;

  assign adc_ready = en & ~pair_full_q & ~reset;
  assign busy      = (state_q != IDLE) | pair_full_q;
  assign err       = err_q;
  assign stall_cnt = stall_q;
  assign flt_start = start_q;
  assign flt_sel   = sel_q;
  assign flt_data  = data_q;
  assign flt_emit  = emit_q;

  always_comb begin
    state_d     = state_q;
    i_reg_d     = i_reg_q;
    q_reg_d     = q_reg_q;
    pair_full_d = pair_full_q;
    dcnt_d      = dcnt_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    stall_d     = stall_q;

    if (adc_valid && adc_ready) begin
      i_reg_d     = adc_i;
      q_reg_d     = adc_q;
      pair_full_d = 1'b1;
    end
    if (adc_valid && !adc_ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (pair_full_q) state_d = START_I;
      end
      START_I: begin
        state_d = WAIT_I;
        wcnt_d  = '0;
      end
      WAIT_I: begin
        if (flt_done) begin
          state_d = START_Q;
        end else if (wcnt_q == WMAX) begin
          state_d     = IDLE;
          err_d       = 1'b1;
          pair_full_d = 1'b0;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      START_Q: begin
        state_d = WAIT_Q;
        wcnt_d  = '0;
      end
      WAIT_Q: begin
        if (flt_done) begin
          state_d     = IDLE;
          pair_full_d = 1'b0;
          dcnt_d      = (dcnt_q == DMAX) ? '0 : dcnt_q + DW'(1);
        end else if (wcnt_q == WMAX) begin
          state_d     = IDLE;
          err_d       = 1'b1;
          pair_full_d = 1'b0;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Moore outputs registered from the next state
    start_d = (state_d == START_I) || (state_d == START_Q);
    sel_d   = (state_d == START_Q);
    data_d  = '0;
    if (state_d == START_I) data_d = i_reg_q;
    if (state_d == START_Q) data_d = q_reg_q;
    emit_d  = start_d && (dcnt_q == DMAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      i_reg_q     <= '0;
      q_reg_q     <= '0;
      pair_full_q <= 1'b0;
      dcnt_q      <= '0;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      stall_q     <= '0;
      start_q     <= 1'b0;
      sel_q       <= 1'b0;
      data_q      <= '0;
      emit_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_reg_q     <= i_reg_d;
      q_reg_q     <= q_reg_d;
      pair_full_q <= pair_full_d;
      dcnt_q      <= dcnt_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
      start_q     <= start_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      emit_q      <= emit_d;
    end
  end

endmodule

// File: tb/tb_iq_filter_sched.sv
// Bench for iq_filter_sched: table vectors, corner sequences and a random
// run, all checked cycle by cycle against a transaction-level model.
module tb_iq_filter_sched;

  localparam int DATA_W  = 12;
  localparam int DECIM   = 2;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              reset, en, adc_valid, flt_done;
  logic [DATA_W-1:0] adc_i, adc_q;
  logic              adc_ready, flt_start, flt_sel, flt_emit;
  logic [DATA_W-1:0] flt_data;
  logic              busy, err;
  logic [15:0]       stall_cnt;

  always #5 clk = ~clk;

  iq_filter_sched #(.DATA_W(DATA_W), .DECIM(DECIM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .en(en),
    .adc_valid(adc_valid), .adc_i(adc_i), .adc_q(adc_q),
    .adc_ready(adc_ready), .flt_start(flt_start), .flt_sel(flt_sel),
    .flt_data(flt_data), .flt_emit(flt_emit), .flt_done(flt_done),
    .busy(busy), .err(err), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit                sel;
    logic [DATA_W-1:0] data;
    bit                emit;
  } job_t;

  typedef struct {
    logic [DATA_W-1:0] i;
    logic [DATA_W-1:0] q;
    int                dly;
    bit                emit;
  } vec_t;

  job_t expq[$];
  vec_t vecs[5];

  int n_cmp = 0, n_bad = 0;
  int t = 0, exp_start = -1;
  bit held = 0, m_err = 0, job_active = 0, job_sel = 0;
  int job_start = 0, eng_cnt = 0, eng_delay = 3;
  int done_pairs = 0, stall_m = 0, n_xfer = 0, n_starts = 0;
  bit last_xfer = 0, rand_eng = 0;
  bit obs_emit_i, obs_emit_q;
  logic [DATA_W-1:0] obs_data_i, obs_data_q;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
    end
  endtask

  task automatic pick_delay();
    int r;
    if (!rand_eng) begin
      eng_cnt = eng_delay;
    end else begin
      r = $urandom_range(0, 99);
      if (r < 3)      eng_cnt = 0;
      else if (r < 6) eng_cnt = TIMEOUT;
      else if (r < 8) eng_cnt = TIMEOUT + 1;
      else            eng_cnt = $urandom_range(1, 6);
    end
  endtask

  // One clock: judge the cycle's handshake, step the model, check outputs
  task automatic cycle();
    bit ready_m, xfer, dn_i, dn_q, abort;
    int stall_n;
    job_t e;
    #1;
    ready_m = en && !held && !reset;
    chk("adc_ready", adc_ready, ready_m);
    xfer  = adc_valid && ready_m;
    dn_i  = job_active && flt_done && !job_sel;
    dn_q  = job_active && flt_done && job_sel;
    abort = job_active && !flt_done && (t == job_start + TIMEOUT);
    stall_n = (adc_valid && !ready_m && stall_m < 65535) ? stall_m + 1 : stall_m;
    @(posedge clk);
    #1;
    t++;
    if (reset) begin
      held = 0; m_err = 0; job_active = 0; expq.delete();
      exp_start = -1; done_pairs = 0; stall_m = 0; last_xfer = 0;
    end else begin
      stall_m = stall_n;
      last_xfer = xfer;
      if (xfer) begin
        held = 1;
        exp_start = t + 1;
        n_xfer++;
        e.emit = (done_pairs % DECIM) == DECIM - 1;
        e.sel = 0; e.data = adc_i; expq.push_back(e);
        e.sel = 1; e.data = adc_q; expq.push_back(e);
      end
      if (dn_i) begin job_active = 0; exp_start = t; end
      if (dn_q) begin job_active = 0; held = 0; done_pairs++; end
      if (abort) begin
        job_active = 0; held = 0; m_err = 1; expq.delete();
      end
    end
    chk("busy", busy, held);
    chk("err", err, m_err);
    chk("stall_cnt", stall_cnt, stall_m);
    chk("flt_start", flt_start, t == exp_start);
    flt_done = 0;
    if (flt_start) begin
      n_starts++;
      if (expq.size() == 0) begin
        chk("start_unexpected", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("flt_sel", flt_sel, e.sel);
        chk("flt_data", flt_data, e.data);
        chk("flt_emit", flt_emit, e.emit);
        job_active = 1; job_start = t; job_sel = e.sel;
        if (!e.sel) begin obs_emit_i = flt_emit; obs_data_i = flt_data; end
        else begin obs_emit_q = flt_emit; obs_data_q = flt_data; end
        pick_delay();
      end
    end else begin
      chk("idle_outputs", {flt_sel, flt_data, flt_emit}, 0);
      if (job_active && eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) flt_done = 1;
      end
    end
  endtask

  task automatic send_pair(input logic [DATA_W-1:0] i, input logic [DATA_W-1:0] q);
    adc_i = i; adc_q = q; adc_valid = 1;
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (last_xfer) break;
    end
    if (!last_xfer) chk("xfer_timeout", 0, 1);
    adc_valid = 0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && held; k++) cycle();
    if (held) chk("idle_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  initial begin
    int s0, x0;
    vecs[0] = '{12'h123, 12'h456, 3, 1'b0};
    vecs[1] = '{12'hFFF, 12'h000, 1, 1'b1};
    vecs[2] = '{12'h800, 12'h7FF, 2, 1'b0};
    vecs[3] = '{12'h0A5, 12'hF5A, 5, 1'b1};
    vecs[4] = '{12'h001, 12'hFFE, 4, 1'b0};

    reset = 1; en = 0; adc_valid = 0; flt_done = 0;
    adc_i = '0; adc_q = '0;
    for (int k = 0; k < 3; k++) cycle();
    chk("rst_start", flt_start, 0);
    chk("rst_busy", busy, 0);
    reset = 0; en = 1;

    for (int v = 0; v < 5; v++) begin
      eng_delay = vecs[v].dly;
      send_pair(vecs[v].i, vecs[v].q);
      wait_idle();
      chk("vec_data_i", obs_data_i, vecs[v].i);
      chk("vec_data_q", obs_data_q, vecs[v].q);
      chk("vec_emit_i", obs_emit_i, vecs[v].emit);
      chk("vec_emit_q", obs_emit_q, vecs[v].emit);
    end

    // watchdog: I job never answered, pair dropped, decimation unchanged
    eng_delay = 0;
    s0 = n_starts;
    send_pair(12'h321, 12'h654);
    wait_idle();
    chk("wd_err", err, 1);
    chk("wd_only_i", n_starts - s0, 1);
    eng_delay = 3;
    send_pair(12'h111, 12'h222);
    wait_idle();
    chk("wd_next_emit", obs_emit_q, 1);
    chk("wd_err_sticky", err, 1);

    // flt_done lands exactly on the timeout cycle
    pulse_reset();
    chk("rst_err_clear", err, 0);
    eng_delay = TIMEOUT;
    send_pair(12'h0F0, 12'h00F);
    wait_idle();
    chk("edge_no_err", err, 0);
    chk("edge_q_data", obs_data_q, 12'h00F);

    // enable dropped right after a transfer
    eng_delay = 3;
    s0 = n_starts;
    send_pair(12'h5A5, 12'hA5A);
    en = 0; adc_valid = 1;
    wait_idle();
    for (int k = 0; k < 5; k++) cycle();
    chk("en_both_jobs", n_starts - s0, 2);
    chk("en_ready_low", adc_ready, 0);
    chk("en_busy_low", busy, 0);
    en = 1; adc_valid = 0;

    // backpressure: valid held high against a slow engine
    eng_delay = 10;
    x0 = n_xfer; s0 = n_starts;
    adc_valid = 1; adc_i = 12'($urandom); adc_q = 12'($urandom);
    for (int k = 0; k < 400 && n_xfer - x0 < 4; k++) begin
      cycle();
      if (last_xfer) begin adc_i = 12'($urandom); adc_q = 12'($urandom); end
    end
    adc_valid = 0;
    wait_idle();
    chk("bp_pairs", n_xfer - x0, 4);
    chk("bp_starts", n_starts - s0, 8);
    chk("bp_queue", expq.size(), 0);

    // reset while the Q job is outstanding
    eng_delay = 20;
    send_pair(12'h777, 12'h888);
    for (int k = 0; k < 100 && !(job_active && job_sel); k++) cycle();
    chk("rq_in_wait_q", job_active && job_sel, 1);
    cycle();
    pulse_reset();
    chk("rq_start", flt_start, 0);
    chk("rq_busy", busy, 0);
    chk("rq_stall", stall_cnt, 0);
    s0 = n_starts;
    for (int k = 0; k < 30; k++) cycle();
    chk("rq_quiet", n_starts - s0, 0);
    eng_delay = 2;
    send_pair(12'h246, 12'h135);
    wait_idle();
    chk("rq_resume_q", obs_data_q, 12'h135);
    chk("rq_resume_emit", obs_emit_i, 0);

    // random traffic with a randomly slow, silent or late engine
    rand_eng = 1;
    for (int k = 0; k < 3000; k++) begin
      adc_valid = ($urandom_range(0, 3) != 0);
      adc_i = 12'($urandom);
      adc_q = 12'($urandom);
      en = ($urandom_range(0, 15) != 0);
      cycle();
    end
    rand_eng = 0; eng_delay = 2;
    adc_valid = 0; en = 1;
    wait_idle();
    for (int k = 0; k < 3; k++) cycle();
    chk("rand_queue", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
